// File: rtl/fd_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer carrying instr, PC, PC+4 and mode bit.
// Optional FDQ_STATS_EN adds high-water and flush-cycle counters.
module fd_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PushF,
    input  logic [XLEN-1:0] InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic            ArmF,
    output logic            ReadyF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ArmD,
    output logic            ValidD,
    output logic [CW-1:0]   CountD
`ifdef FDQ_STATS_EN
    ,
    output logic [CW-1:0]   HighWaterD,
    output logic [15:0]     FlushCntD
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc4_q   [DEPTH];
    logic [DEPTH-1:0] arm_q;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    always_comb begin
        ValidD    = (count != '0);
        ReadyF    = (count != CW'(DEPTH));
        push      = PushF & ReadyF & ~FlushD;
        pop       = ValidD & ~StallD & ~FlushD;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Head fields read combinationally, masked to zero while the queue is empty.
    always_comb begin
        InstrD   = '0;
        PCD      = '0;
        PCPlus4D = '0;
        ArmD     = 1'b0;
        if (ValidD) begin
            InstrD   = instr_q[rd_ptr];
            PCD      = pc_q[rd_ptr];
            PCPlus4D = pc4_q[rd_ptr];
            ArmD     = arm_q[rd_ptr];
        end
    end

    assign CountD = count;

    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= InstrF;
            pc_q[wr_ptr]    <= PCF;
            pc4_q[wr_ptr]   <= PCPlus4F;
            arm_q[wr_ptr]   <= ArmF;
        end
    end

`ifdef FDQ_STATS_EN
    // Tracking count_nxt keeps the high-water mark current with CountD; flush never raises it.
    always_ff @(posedge clk) begin
        if (rst) begin
            HighWaterD <= '0;
            FlushCntD  <= '0;
        end else begin
            if (!FlushD && count_nxt > HighWaterD) HighWaterD <= count_nxt;
            if (FlushD && FlushCntD != 16'hFFFF)   FlushCntD  <= FlushCntD + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fd_queue.sv
// Self-checking bench for fd_queue: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fd_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            PushF;
    logic [XLEN-1:0] InstrF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;
    logic            ArmF;
    logic            ReadyF;
    logic            StallD;
    logic            FlushD;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ArmD;
    logic            ValidD;
    logic [CW-1:0]   CountD;
`ifdef FDQ_STATS_EN
    logic [CW-1:0]   HighWaterD;
    logic [15:0]     FlushCntD;
`endif

    fd_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .PushF(PushF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ArmF(ArmF),
        .ReadyF(ReadyF), .StallD(StallD), .FlushD(FlushD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ArmD(ArmD),
        .ValidD(ValidD), .CountD(CountD)
`ifdef FDQ_STATS_EN
        , .HighWaterD(HighWaterD), .FlushCntD(FlushCntD)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        push, stall, flush;
        logic [31:0] instr, pc;
        logic        arm;
        logic        e_valid;
        logic [31:0] e_count;
        logic        e_ready;
        logic [31:0] e_instr, e_pc;
        logic        e_arm;
    } vec_t;

    function automatic vec_t mk(logic p, logic s, logic f, logic [31:0] i, logic [31:0] pc, logic a,
                                logic ev, int ec, logic er, logic [31:0] ei, logic [31:0] ep, logic ea);
        vec_t v;
        v.push = p; v.stall = s; v.flush = f; v.instr = i; v.pc = pc; v.arm = a;
        v.e_valid = ev; v.e_count = ec; v.e_ready = er; v.e_instr = ei; v.e_pc = ep; v.e_arm = ea;
        return v;
    endfunction

    typedef struct {
        logic [31:0] instr, pc, pc4;
        logic        arm;
    } ent_t;

    task automatic idle_inputs();
        PushF = 0; StallD = 0; FlushD = 0; InstrF = '0; PCF = '0; PCPlus4F = '0; ArmF = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic drive(input logic p, input logic s, input logic f,
                         input logic [31:0] i, input logic [31:0] pc, input logic a);
        PushF = p; StallD = s; FlushD = f; InstrF = i; PCF = pc; PCPlus4F = pc + 32'd4; ArmF = a;
    endtask

    vec_t vecs[$];
    ent_t model[$];

    initial begin
        // push, stall, flush, instr, pc, arm  ->  valid, count, ready, instr, pc, arm (after the edge)
        vecs.push_back(mk(1,0,0,32'h00500093,32'h100,0, 1,1,1,32'h00500093,32'h100,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,1,0,0,0));
        vecs.push_back(mk(1,1,0,32'hA1,32'h200,0,       1,1,1,32'hA1,32'h200,0));
        vecs.push_back(mk(1,1,0,32'hA2,32'h204,0,       1,2,1,32'hA1,32'h200,0));
        vecs.push_back(mk(1,1,0,32'hA3,32'h208,0,       1,3,1,32'hA1,32'h200,0));
        vecs.push_back(mk(1,1,0,32'hA4,32'h20C,0,       1,4,0,32'hA1,32'h200,0));
        vecs.push_back(mk(1,1,0,32'hA5,32'h210,0,       1,4,0,32'hA1,32'h200,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  1,3,1,32'hA2,32'h204,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  1,2,1,32'hA3,32'h208,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  1,1,1,32'hA4,32'h20C,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,1,0,0,0));
        vecs.push_back(mk(1,1,0,32'hE3A00001,32'h300,1, 1,1,1,32'hE3A00001,32'h300,1));
        vecs.push_back(mk(1,1,0,32'h00100093,32'h304,0, 1,2,1,32'hE3A00001,32'h300,1));
        vecs.push_back(mk(1,1,0,32'h00200113,32'h308,0, 1,3,1,32'hE3A00001,32'h300,1));
        vecs.push_back(mk(0,0,0,0,0,0,                  1,2,1,32'h00100093,32'h304,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  1,1,1,32'h00200113,32'h308,0));
        vecs.push_back(mk(1,1,0,32'hB1,32'h400,0,       1,2,1,32'h00200113,32'h308,0));
        vecs.push_back(mk(1,1,0,32'hB2,32'h404,1,       1,3,1,32'h00200113,32'h308,0));
        vecs.push_back(mk(1,1,1,32'hB3,32'h408,0,       0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,1,0,0,0));
        vecs.push_back(mk(1,1,0,32'hC1,32'h500,0,       1,1,1,32'hC1,32'h500,0));
        vecs.push_back(mk(1,1,0,32'hC2,32'h504,1,       1,2,1,32'hC1,32'h500,0));
        vecs.push_back(mk(1,1,0,32'hC3,32'h508,0,       1,3,1,32'hC1,32'h500,0));
        vecs.push_back(mk(1,1,0,32'hC4,32'h50C,1,       1,4,0,32'hC1,32'h500,0));
        vecs.push_back(mk(1,0,0,32'hC5,32'h510,0,       1,3,1,32'hC2,32'h504,1));
        vecs.push_back(mk(1,0,0,32'hC5,32'h510,0,       1,3,1,32'hC3,32'h508,0));
        vecs.push_back(mk(0,0,1,0,0,0,                  0,0,1,0,0,0));

        do_reset();
        chk("reset_valid", 32'(ValidD), 0);
        chk("reset_count", 32'(CountD), 0);
        chk("reset_ready", 32'(ReadyF), 1);
        chk("reset_instr", InstrD, 0);
        chk("reset_pc",    PCD, 0);
        chk("reset_pc4",   PCPlus4D, 0);
        chk("reset_arm",   32'(ArmD), 0);

        foreach (vecs[k]) begin
            drive(vecs[k].push, vecs[k].stall, vecs[k].flush, vecs[k].instr, vecs[k].pc, vecs[k].arm);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", k), 32'(ValidD), 32'(vecs[k].e_valid));
            chk($sformatf("vec%0d_count", k), 32'(CountD), vecs[k].e_count);
            chk($sformatf("vec%0d_ready", k), 32'(ReadyF), 32'(vecs[k].e_ready));
            chk($sformatf("vec%0d_instr", k), InstrD, vecs[k].e_instr);
            chk($sformatf("vec%0d_pc", k),    PCD, vecs[k].e_pc);
            chk($sformatf("vec%0d_pc4", k),   PCPlus4D, vecs[k].e_valid ? vecs[k].e_pc + 32'd4 : 32'd0);
            chk($sformatf("vec%0d_arm", k),   32'(ArmD), 32'(vecs[k].e_arm));
        end

        // Steady push+pop at occupancy 2 for 10 cycles; pointers wrap more than twice.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 0, 32'hD000_0000 + k, 32'h600 + 4*k, k[0]);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 32'hD000_0002 + k, 32'h608 + 4*k, ~k[0]);
            @(posedge clk); #1;
            chk($sformatf("pp%0d_count", k), 32'(CountD), 2);
            chk($sformatf("pp%0d_instr", k), InstrD, 32'hD000_0001 + k);
            chk($sformatf("pp%0d_pc4", k),   PCPlus4D, 32'h604 + 4*k + 4);
        end
        idle_inputs();

`ifdef FDQ_STATS_EN
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 32'hF0 + k, 32'h700 + 4*k, 0);
            @(posedge clk); #1;
        end
        chk("hw_full", 32'(HighWaterD), 4);
        drive(0, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        chk("hw_after_flush", 32'(HighWaterD), 4);
        chk("flushcnt", 32'(FlushCntD), 2);
        do_reset();
        chk("hw_rst", 32'(HighWaterD), 0);
        chk("flushcnt_rst", 32'(FlushCntD), 0);
`endif

        // Randomized traffic against a queue model; inputs change on negedge, outputs checked there too.
        do_reset();
        model.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            ent_t e;
            logic m_ready, m_valid, r, p, s, f;
            @(negedge clk);
            m_valid = (model.size() != 0);
            m_ready = (model.size() != DEPTH);
            chk("rnd_valid", 32'(ValidD), 32'(m_valid));
            chk("rnd_ready", 32'(ReadyF), 32'(m_ready));
            chk("rnd_count", 32'(CountD), model.size());
            chk("rnd_instr", InstrD,   m_valid ? model[0].instr : 32'd0);
            chk("rnd_pc",    PCD,      m_valid ? model[0].pc    : 32'd0);
            chk("rnd_pc4",   PCPlus4D, m_valid ? model[0].pc4   : 32'd0);
            chk("rnd_arm",   32'(ArmD), m_valid ? 32'(model[0].arm) : 32'd0);

            r = ($urandom_range(0, 49) == 0);
            p = ($urandom_range(0, 9) < 6);
            s = ($urandom_range(0, 9) < 4);
            f = ($urandom_range(0, 19) == 0);
            e.instr = $urandom; e.pc = $urandom; e.pc4 = e.pc + 32'd4; e.arm = $urandom_range(0, 1);
            rst = r; PushF = p; StallD = s; FlushD = f;
            InstrF = e.instr; PCF = e.pc; PCPlus4F = e.pc4; ArmF = e.arm;

            @(posedge clk);
            if (r || f) model.delete();
            else begin
                if (m_valid && !s) void'(model.pop_front());
                if (p && m_ready) model.push_back(e);
            end
        end
        rst = 0;
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
